// File: rtl/riscv_pkg.sv
// Shared load/store definitions for the MEM-stage data-memory master: funct3 encodings,
// FSM state type and small helpers for legality, lane enables and store-data replication.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWaitData,
    StDone
  } lsu_state_t;

  // Unsigned loads have no store counterpart, so stores only accept B/H/W.
  function automatic logic access_legal(input logic is_store, input logic [2:0] f3,
                                        input logic [1:0] off);
    logic ok;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_BU:   ok = !is_store;
      F3_H:    ok = !off[0];
      F3_HU:   ok = !is_store && !off[0];
      F3_W:    ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] byteenable_of(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3)
      F3_B, F3_BU: be = 4'b0001 << off;
      F3_H, F3_HU: be = 4'b0011 << off;
      F3_W:        be = 4'b1111;
      default:     be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] writedata_of(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    case (f3)
      F3_B:    r = {4{wd[7:0]}};
      F3_H:    r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_avalon_master_if.sv
// Avalon-MM data-memory bus between the MEM-stage master and the memory slave.
interface dmem_avalon_master_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [3:0]        avm_byteenable;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;
  logic              avm_waitrequest;
  logic              avm_readdatavalid;

  modport master (
    output avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
    input  avm_readdata, avm_waitrequest, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
    output avm_readdata, avm_waitrequest, avm_readdatavalid
  );
endinterface

// File: rtl/lsu_load_align.sv
// Load data alignment: moves the addressed lane to bit 0, then sign- or zero-extends.
module lsu_load_align
  import riscv_pkg::*;
(
  input  logic [31:0] readdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = readdata >> {offset, 3'b000};
    case (funct3)
      F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   data = {24'h0, shifted[7:0]};
      F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   data = {16'h0, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/dmem_avalon_master.sv
// MEM-stage load/store master: turns pipeline requests into Avalon-MM transfers and stalls
// the pipeline until the transfer finishes.
module dmem_avalon_master
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_read,
  input  logic                       mem_write,
  input  logic [2:0]                 funct3,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [31:0]                wdata,
  output logic [31:0]                rdata,
  output logic                       stall,
  output logic                       misalign,
  dmem_avalon_master_if.master       avm
);

  lsu_state_t        state_q, state_d;
  logic              read_q, write_q, is_store_q;
  logic [ADDR_W-1:0] address_q;
  logic [3:0]        be_q;
  logic [31:0]       writedata_q, rdata_q, load_data;
  logic [1:0]        off_q;
  logic [2:0]        f3_q;

  logic req, is_store, legal, accept;

  // A simultaneous read and write is handled as a read.
  assign req      = mem_read | mem_write;
  assign is_store = mem_write & ~mem_read;
  assign legal    = access_legal(is_store, funct3, addr[1:0]);
  assign accept   = (state_q == StIdle) && req && legal;

  always_comb begin
    state_d  = state_q;
    stall    = 1'b0;
    misalign = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req && legal) begin
          stall   = 1'b1;
          state_d = StReq;
        end else if (req) begin
          misalign = ~rst;
        end
      end
      StReq: begin
        stall = 1'b1;
        if (!avm.avm_waitrequest) state_d = is_store_q ? StDone : StWaitData;
      end
      StWaitData: begin
        stall = 1'b1;
        if (avm.avm_readdatavalid) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  lsu_load_align u_align (
    .readdata (avm.avm_readdata),
    .offset   (off_q),
    .funct3   (f3_q),
    .data     (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      is_store_q  <= 1'b0;
      address_q   <= '0;
      be_q        <= 4'b0000;
      writedata_q <= 32'h0;
      rdata_q     <= 32'h0;
      off_q       <= 2'b00;
      f3_q        <= 3'b000;
    end else begin
      state_q <= state_d;
      if (accept) begin
        read_q      <= ~is_store;
        write_q     <= is_store;
        is_store_q  <= is_store;
        address_q   <= {addr[ADDR_W-1:2], 2'b00};
        be_q        <= byteenable_of(funct3, addr[1:0]);
        writedata_q <= writedata_of(funct3, wdata);
        off_q       <= addr[1:0];
        f3_q        <= funct3;
      end
      if (state_q == StReq && !avm.avm_waitrequest) begin
        read_q  <= 1'b0;
        write_q <= 1'b0;
      end
      if (state_q == StWaitData && avm.avm_readdatavalid) rdata_q <= load_data;
    end
  end

  assign avm.avm_address    = address_q;
  assign avm.avm_read       = read_q;
  assign avm.avm_write      = write_q;
  assign avm.avm_byteenable = be_q;
  assign avm.avm_writedata  = writedata_q;
  assign rdata              = rdata_q;

endmodule

// File: tb/tb_dmem_avalon_master.sv
// Bench for dmem_avalon_master: a transaction-level model predicts the bus fields, stall
// timeline and load result for directed and random accesses against a simple slave.
module tb_dmem_avalon_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic [31:0] rdata;
  logic        stall, misalign;

  int checks = 0;
  int errors = 0;
  logic [31:0] prev_rdata = 32'h0;
  int          obs_stall;
  logic [3:0]  obs_be;
  logic [31:0] obs_wd, obs_rdata, obs_addr;
  logic        obs_mis;

  dmem_avalon_master_if #(.ADDR_W(32)) bus ();

  dmem_avalon_master #(.ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .misalign  (misalign),
    .avm       (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rules for an access, expressed as byte arithmetic.
  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b0;
    if (st && f3 > 3'd2) return 1'b0;
    return (a % nbytes(f3)) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    logic [7:0] m;
    m = 8'((1 << nbytes(f3)) - 1) << a[1:0];
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nbytes(f3)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off,
                                         input logic [31:0] w);
    logic [31:0] v, mask;
    int b;
    b = nbytes(f3);
    v = w >> (8 * off);
    if (b == 4) return v;
    mask = (32'h1 << (8 * b)) - 32'h1;
    v = v & mask;
    if (!f3[2] && v[8*b-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic idle_cycle();
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    bus.avm_waitrequest = 1'b0; bus.avm_readdatavalid = 1'b0; bus.avm_readdata = $urandom;
    #1;
    chk("idle_stall", {31'b0, stall}, 32'h0);
    chk("idle_misalign", {31'b0, misalign}, 32'h0);
    chk("idle_cmd", {30'b0, bus.avm_read, bus.avm_write}, 32'h0);
    chk("idle_rdata", rdata, prev_rdata);
  endtask

  // One pipeline access: wait_n waitrequest cycles, read data lat cycles after acceptance.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input int wait_n,
                        input int lat, input logic [31:0] rword);
    bit is_rd, is_st, legal;
    int total;
    logic [31:0] exp_rd;
    is_rd = rd;
    is_st = wr & ~rd;
    legal = m_legal(is_st, f3, a);
    exp_rd = m_load(f3, a[1:0], rword);
    obs_stall = 0;
    obs_be = 4'h0;
    obs_wd = 32'h0;
    obs_addr = 32'h0;

    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    bus.avm_waitrequest = (wait_n > 0); bus.avm_readdatavalid = 1'b0;
    bus.avm_readdata = $urandom;
    #1;
    obs_mis = misalign;
    if (stall) obs_stall++;
    chk("req_stall", {31'b0, stall}, {31'b0, legal});
    chk("req_misalign", {31'b0, misalign}, {31'b0, ~legal});
    chk("req_cmd", {30'b0, bus.avm_read, bus.avm_write}, 32'h0);
    if (!legal) return;

    total = 1 + wait_n + 1 + (is_rd ? lat : 0);
    for (int c = 1; c <= total; c++) begin
      @(posedge clk); #1;
      bus.avm_waitrequest = (c <= wait_n);
      bus.avm_readdatavalid = is_rd && (c == total - 1) && (c > wait_n + 1);
      bus.avm_readdata = bus.avm_readdatavalid ? rword : $urandom;
      #1;
      if (stall) obs_stall++;
      if (c <= wait_n + 1) begin
        chk("cmd_read", {31'b0, bus.avm_read}, {31'b0, is_rd});
        chk("cmd_write", {31'b0, bus.avm_write}, {31'b0, is_st});
        chk("cmd_addr", bus.avm_address, {a[31:2], 2'b00});
        chk("cmd_be", {28'b0, bus.avm_byteenable}, {28'b0, m_be(f3, a)});
        if (is_st) chk("cmd_wdata", bus.avm_writedata, m_wd(f3, wd));
        chk("cmd_stall", {31'b0, stall}, 32'h1);
        chk("cmd_rdata_hold", rdata, prev_rdata);
        obs_be = bus.avm_byteenable;
        obs_wd = bus.avm_writedata;
        obs_addr = bus.avm_address;
      end else if (c < total) begin
        chk("data_cmd", {30'b0, bus.avm_read, bus.avm_write}, 32'h0);
        chk("data_stall", {31'b0, stall}, 32'h1);
      end else begin
        chk("done_stall", {31'b0, stall}, 32'h0);
        chk("done_cmd", {30'b0, bus.avm_read, bus.avm_write}, 32'h0);
        if (is_rd) prev_rdata = exp_rd;
        chk("done_rdata", rdata, prev_rdata);
        obs_rdata = rdata;
      end
    end
  endtask

  initial begin
    bus.avm_readdata = 32'h0;
    bus.avm_waitrequest = 1'b0;
    bus.avm_readdatavalid = 1'b0;

    repeat (2) @(posedge clk);
    #2;
    chk("rst_cmd", {30'b0, bus.avm_read, bus.avm_write}, 32'h0);
    chk("rst_addr", bus.avm_address, 32'h0);
    chk("rst_be", {28'b0, bus.avm_byteenable}, 32'h0);
    chk("rst_wdata", bus.avm_writedata, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_misalign", {31'b0, misalign}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset while waiting for read data; the late readdatavalid must be ignored.
    @(posedge clk); #1;
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h200;
    @(posedge clk); #1;
    #1 chk("mid_req_read", {31'b0, bus.avm_read}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1 chk("mid_wait_stall", {31'b0, stall}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b0; mem_read = 1'b0;
    bus.avm_readdatavalid = 1'b1; bus.avm_readdata = 32'h12345678;
    #1;
    chk("mid_rst_stall", {31'b0, stall}, 32'h0);
    chk("mid_rst_cmd", {30'b0, bus.avm_read, bus.avm_write}, 32'h0);
    chk("mid_rst_rdata", rdata, 32'h0);
    idle_cycle();
    chk("mid_rst_rdata_after", rdata, 32'h0);

    access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 1, 32'h0);
    chk("sw_stall_cycles", obs_stall, 32'd2);
    chk("sw_be", {28'b0, obs_be}, 32'hF);
    chk("sw_addr", obs_addr, 32'h100);
    idle_cycle();
    access(1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 0, 1, 32'h0);
    chk("sb_be", {28'b0, obs_be}, 32'h8);
    chk("sb_wdata", obs_wd, 32'hA5A5A5A5);
    access(1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 0, 1, 32'h0080FF00);
    chk("lb_rdata", obs_rdata, 32'hFFFFFF80);
    chk("lb_stall_cycles", obs_stall, 32'd3);
    access(1'b1, 1'b0, 3'b100, 32'h102, 32'h0, 0, 1, 32'h0080FF00);
    chk("lbu_rdata", obs_rdata, 32'h00000080);
    access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 2, 2, 32'h80010000);
    chk("lh_stall_cycles", obs_stall, 32'd6);
    chk("lh_rdata", obs_rdata, 32'hFFFF8001);
    access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 0, 1, 32'h0);
    chk("lw_mis_pulse", {31'b0, obs_mis}, 32'h1);
    chk("lw_mis_stall", obs_stall, 32'd0);
    idle_cycle();
    access(1'b1, 1'b1, 3'b101, 32'h306, 32'h11223344, 1, 1, 32'hBEEF1234);
    chk("rw_both_rdata", obs_rdata, 32'h0000BEEF);

    for (int i = 0; i < 120; i++) begin
      logic rd, wr;
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'($urandom_range(0, 3) == 0) : 1'b1;
      access(rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), $urandom);
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end
    idle_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
